demodchest_out_framer: RTL
==========================

Name: demodchest_out_framer

Overview:
- Downstream stage of the demodulator/channel-estimator IP inside the demodchest RFNoC block.
- Sits between the IP's 32-bit AXIS master (which carries only tlast) and the noc_shell `s_out_axis_*` port.
- Buffers IP output into packets of at most `spp` items and emits each packet with the full sideband: tlength, ttimestamp, thas_time, teob, teov, tkeep.
- Because every packet is fully buffered before it is emitted, tlength is known on the packet's first output word.

Parameters:
- ITEM_W, 32, item width in bits (fixed by the IP output width).
- BUF_LOG2, 8, log2 of packet buffer depth in items; maximum packet size is 2**BUF_LOG2.

Ports:
- axis_data_clk  in  1  sole clock.
- axis_data_rst  in  1  reset, synchronous, active-high.
- cfg_spp  in  16  items per packet; sampled at burst start.
- cfg_has_time  in  1  burst carries a timestamp; sampled at burst start.
- cfg_start_time  in  64  timestamp of the first item of the burst; sampled at burst start.
- s_axis_tdata  in  ITEM_W  data from the IP master.
- s_axis_tlast  in  1  end of burst (IP frame end).
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  ITEM_W  data to noc_shell s_out_axis.
- m_axis_tkeep  out  1  constant 1.
- m_axis_tlast  out  1  last word of packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_ttimestamp  out  64  timestamp of the packet's first item.
- m_axis_thas_time  out  1  timestamp valid.
- m_axis_tlength  out  16  payload length in bytes (items*ITEM_W/8).
- m_axis_teov  out  1  constant 0.
- m_axis_teob  out  1  last packet of the burst.
- pkt_count  out  32  packets emitted since reset; wraps.

Behaviour:
- Reset: state IDLE; all counters 0; `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_teob`=0; timestamp register 0; `pkt_count`=0.
- `m_axis_tkeep`=1 and `m_axis_teov`=0 at all times.
- States: IDLE, FILL, DRAIN.
- IDLE:
  - `s_axis_tready`=0 for exactly one cycle.
  - Latch `spp_eff` = clamp(`cfg_spp`): 0 → 2**BUF_LOG2; values > 2**BUF_LOG2 → 2**BUF_LOG2; otherwise `cfg_spp`.
  - Latch `cfg_has_time` and `cfg_start_time` into `ts`.
  - Go to FILL.
- FILL:
  - `s_axis_tready`=1.
  - Each input handshake writes `buf[wr_cnt]` and increments `wr_cnt`.
  - On the beat where `wr_cnt+1` == `spp_eff`, or `s_axis_tlast`=1: record `len` = `wr_cnt+1`, set `eob_pend` = `s_axis_tlast`, go to DRAIN; `s_axis_tready` drops the following cycle.
  - If tlast and the spp limit coincide, the packet length is `spp_eff` and `eob_pend`=1.
- DRAIN:
  - `s_axis_tready`=0 (input fully stalled; throughput at most 50%, acceptable for the demod output rate).
  - Output words `buf[0..len-1]` in order.
  - `m_axis_tvalid`=1 from the first DRAIN cycle after buffer read latency; at most 1 cycle of bubble per packet.
  - Read is registered: data is held stable while `tvalid`=1 and `tready`=0.
  - `tlength`, `ttimestamp`, `thas_time` and `teob`(=`eob_pend`) are constant for the whole packet.
  - `tlast`=1 on word `len-1`.
  - On the tlast handshake:
    - `pkt_count`++.
    - `ts` += `len` (64-bit modulo).
    - `wr_cnt`=0.
    - If `eob_pend`, go to IDLE (new burst, resample config); else go to FILL (same burst, `spp_eff` and `has_time` kept).
- Config inputs are ignored except in IDLE.
- `tlength` = `len` << 2 for ITEM_W=32; maximum 1024 bytes at BUF_LOG2=8.
- An input tlast with no preceding data produces a 1-item packet with teob=1; a zero-length packet is never emitted.
- Downstream backpressure of any duration loses no data; the output holds.
- Reset asserted mid-FILL or mid-DRAIN:
  - Next cycle is the reset state.
  - The partially buffered packet is discarded and no partial packet is emitted.
  - `pkt_count` clears to 0.

Test Plan:
- spp=4, has_time=1, start=1000; 10 items, tlast on item 10 → 3 packets: lengths 16/16/8 bytes, ts 1000/1004/1008, teob 0/0/1, data order preserved, pkt_count=3.
- spp=0 and spp=300 with BUF_LOG2=8; 600 items no tlast then tlast → each case emits packets of 256 items (tlength=1024); final packet carries teob=1.
- spp=5, tlast on item 5 → single packet, tlength=20, teob=1; next burst resamples cfg (spp=2, has_time=0) → 2-item packets with thas_time=0.
- Random `m_axis_tready` (30% duty) with random `s_axis_tvalid` gaps over 10k items → scoreboard matches exactly; tdata/tlength/teob stable while stalled; no input accepted during DRAIN.
- Lone tlast on the first input item → one packet with tlength=4, tlast=1, teob=1.
- Reset asserted after 3 of 8 items in FILL, and again mid-DRAIN with tready=0 → no output of the partial packet; all outputs at reset values; the next burst frames correctly from ts=`cfg_start_time`.

Source files
------------

// File: rtl/demodchest_out_framer_if.sv
// demodchest_out_framer_if: IP-side AXIS input and noc_shell-side AXIS output with RFNoC sideband.
interface demodchest_out_framer_if #(
    parameter int ITEM_W = 32
);
    logic [ITEM_W-1:0] s_axis_tdata;
    logic              s_axis_tlast;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [ITEM_W-1:0] m_axis_tdata;
    logic              m_axis_tkeep;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [63:0]       m_axis_ttimestamp;
    logic              m_axis_thas_time;
    logic [15:0]       m_axis_tlength;
    logic              m_axis_teov;
    logic              m_axis_teob;

    modport master (
        input  s_axis_tdata, s_axis_tlast, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
               m_axis_ttimestamp, m_axis_thas_time, m_axis_tlength, m_axis_teov, m_axis_teob
    );

    modport slave (
        output s_axis_tdata, s_axis_tlast, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
               m_axis_ttimestamp, m_axis_thas_time, m_axis_tlength, m_axis_teov, m_axis_teob
    );
endinterface

// File: rtl/demodchest_out_framer.sv
// demodchest_out_framer: buffers IP output into packets of up to spp items, emitting each with full sideband.
module demodchest_out_framer #(
    parameter int ITEM_W   = 32,
    parameter int BUF_LOG2 = 8
) (
    input  logic                    axis_data_clk,
    input  logic                    axis_data_rst,
    input  logic [15:0]             cfg_spp,
    input  logic                    cfg_has_time,
    input  logic [63:0]             cfg_start_time,
    demodchest_out_framer_if.master bus,
    output logic [31:0]             pkt_count
);
    localparam int DEPTH = 1 << BUF_LOG2;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t              state, state_nx;
    logic [ITEM_W-1:0]   mem [DEPTH];
    logic [BUF_LOG2:0]   spp_eff, spp_clamp, wr_cnt, rd_cnt, len;
    logic [63:0]         ts;
    logic [ITEM_W-1:0]   out_data;
    logic                out_valid, out_last, eob_pend, has_time;
    logic                in_hs, in_end, out_end, load;

    assign spp_clamp = (cfg_spp == 16'd0 || 32'(cfg_spp) > DEPTH) ? (BUF_LOG2+1)'(DEPTH) : cfg_spp[BUF_LOG2:0];
    assign in_hs     = bus.s_axis_tvalid && bus.s_axis_tready;
    assign in_end    = in_hs && (wr_cnt + 1'b1 == spp_eff || bus.s_axis_tlast);
    assign out_end   = state == DRAIN && out_valid && out_last && bus.m_axis_tready;
    // Registered read: the next word is fetched only when the output register is empty or being consumed.
    assign load      = state == DRAIN && rd_cnt != len && (!out_valid || bus.m_axis_tready);

    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = FILL;
        if (in_end) state_nx = DRAIN;
        if (out_end) state_nx = eob_pend ? IDLE : FILL;
    end

    always_ff @(posedge axis_data_clk) begin
        if (in_hs) mem[wr_cnt[BUF_LOG2-1:0]] <= bus.s_axis_tdata;
    end

    always_ff @(posedge axis_data_clk) begin
        if (axis_data_rst) begin
            state     <= IDLE;
            spp_eff   <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            len       <= '0;
            ts        <= '0;
            has_time  <= 1'b0;
            eob_pend  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            pkt_count <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                spp_eff  <= spp_clamp;
                has_time <= cfg_has_time;
                ts       <= cfg_start_time;
            end
            if (in_hs) wr_cnt <= wr_cnt + 1'b1;
            if (in_end) begin
                len      <= wr_cnt + 1'b1;
                eob_pend <= bus.s_axis_tlast;
                rd_cnt   <= '0;
            end
            if (out_end) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                pkt_count <= pkt_count + 1'b1;
                ts        <= ts + 64'(len);
                wr_cnt    <= '0;
            end else if (load) begin
                out_data  <= mem[rd_cnt[BUF_LOG2-1:0]];
                out_valid <= 1'b1;
                out_last  <= rd_cnt == len - 1'b1;
                rd_cnt    <= rd_cnt + 1'b1;
            end
        end
    end

    assign bus.s_axis_tready     = state == FILL;
    assign bus.m_axis_tdata      = out_data;
    assign bus.m_axis_tvalid     = out_valid;
    assign bus.m_axis_tlast      = out_last;
    assign bus.m_axis_tkeep      = 1'b1;
    assign bus.m_axis_teov       = 1'b0;
    assign bus.m_axis_teob       = eob_pend;
    assign bus.m_axis_ttimestamp = ts;
    assign bus.m_axis_thas_time  = has_time;
    assign bus.m_axis_tlength    = 16'(len * (ITEM_W / 8));
endmodule
